// File: rtl/sync_fifo_mc_pkg.sv
// sync_fifo_mc_pkg: shared count type and count_o slice offset helper
package sync_fifo_mc_pkg;
  localparam int DEF_SIZE = 4;
  typedef logic [$clog2(DEF_SIZE):0] count_t;
  function automatic int count_off(input int c, input int aw);
    return c * (aw + 1);
  endfunction
endpackage

// File: rtl/sync_fifo_chan_ctrl.sv
// sync_fifo_chan_ctrl: head/tail/count and status flags for one channel
module sync_fifo_chan_ctrl #(
  parameter int SIZE = 4,
  parameter int ALMOST_FULL_THRESHOLD = SIZE,
  parameter int ALMOST_EMPTY_THRESHOLD = 1,
  localparam int AW = $clog2(SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          enq,
  input  logic          deq,
  output logic [AW-1:0] head,
  output logic [AW-1:0] tail,
  output logic [AW:0]   count,
  output logic          full,
  output logic          almost_full,
  output logic          empty,
  output logic          almost_empty
);
  localparam logic [AW:0] FULL_C = (AW+1)'(SIZE);
  localparam logic [AW:0] AF_C = (AW+1)'(ALMOST_FULL_THRESHOLD);
  localparam logic [AW:0] AE_C = (AW+1)'(ALMOST_EMPTY_THRESHOLD);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      if (enq && !deq) count <= count + 1'b1;
      else if (deq && !enq) count <= count - 1'b1;
    end
  end
  assign full = count == FULL_C;
  assign almost_full = count >= AF_C;
  assign empty = count == '0;
  assign almost_empty = count <= AE_C;
endmodule

// File: rtl/sync_fifo_mc.sv
// sync_fifo_mc: multi-channel FIFO sharing one storage array, with flush and sticky errors
module sync_fifo_mc
  import sync_fifo_mc_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SIZE = 4,
  parameter int NUM_CHANNELS = 4,
  parameter int ALMOST_FULL_THRESHOLD = SIZE,
  parameter int ALMOST_EMPTY_THRESHOLD = 1,
  localparam int AW = $clog2(SIZE),
  localparam int CW = $clog2(NUM_CHANNELS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CHANNELS-1:0]      flush_en,
  input  logic                         enqueue_en,
  input  logic [CW-1:0]                enqueue_chan,
  input  logic [WIDTH-1:0]             value_i,
  input  logic                         dequeue_en,
  input  logic [CW-1:0]                dequeue_chan,
  output logic [WIDTH-1:0]             value_o,
  output logic [NUM_CHANNELS-1:0]      full,
  output logic [NUM_CHANNELS-1:0]      almost_full,
  output logic [NUM_CHANNELS-1:0]      empty,
  output logic [NUM_CHANNELS-1:0]      almost_empty,
  output logic [NUM_CHANNELS*(AW+1)-1:0] count_o,
  input  logic                         err_clr,
  output logic                         overflow_err,
  output logic                         underflow_err
);
  logic [WIDTH-1:0] mem [NUM_CHANNELS*SIZE];
  logic [AW-1:0] head [NUM_CHANNELS];
  logic [AW-1:0] tail [NUM_CHANNELS];
  logic enq_live, deq_live, enq_ok, deq_ok;
  assign enq_live = enqueue_en && !flush_en[enqueue_chan];
  assign deq_live = dequeue_en && !flush_en[dequeue_chan];
  assign deq_ok = deq_live && !empty[dequeue_chan];
  assign enq_ok = enq_live && (!full[enqueue_chan] || (dequeue_en && dequeue_chan == enqueue_chan));
  genvar c;
  generate
    for (c = 0; c < NUM_CHANNELS; c++) begin : g_ch
      logic [AW:0] cnt;
      sync_fifo_chan_ctrl #(
        .SIZE(SIZE),
        .ALMOST_FULL_THRESHOLD(ALMOST_FULL_THRESHOLD),
        .ALMOST_EMPTY_THRESHOLD(ALMOST_EMPTY_THRESHOLD)
      ) u_ctrl (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush_en[c]),
        .enq(enq_ok && enqueue_chan == CW'(c)),
        .deq(deq_ok && dequeue_chan == CW'(c)),
        .head(head[c]),
        .tail(tail[c]),
        .count(cnt),
        .full(full[c]),
        .almost_full(almost_full[c]),
        .empty(empty[c]),
        .almost_empty(almost_empty[c])
      );
      assign count_o[count_off(c, AW) +: AW+1] = cnt;
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (enq_ok) mem[{enqueue_chan, tail[enqueue_chan]}] <= value_i;
  end
  assign value_o = mem[{dequeue_chan, head[dequeue_chan]}];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      overflow_err  <= (enq_live && !enq_ok) || (overflow_err && !err_clr);
      underflow_err <= (deq_live && !deq_ok) || (underflow_err && !err_clr);
    end
  end
endmodule

// File: tb/tb_sync_fifo_mc.sv
// tb_sync_fifo_mc: directed and random stimulus checked against a queue-based reference model
module tb_sync_fifo_mc;
  localparam int SZ = 4;
  logic clk = 0;
  logic rst_n = 0;
  logic [3:0] flush_en = 0;
  logic enqueue_en = 0;
  logic [1:0] enqueue_chan = 0;
  logic [63:0] value_i = 0;
  logic dequeue_en = 0;
  logic [1:0] dequeue_chan = 0;
  logic [63:0] value_o;
  logic [3:0] full, almost_full, empty, almost_empty;
  logic [11:0] count_o;
  logic err_clr = 0;
  logic overflow_err, underflow_err;
  int vectors = 0;
  int miscompares = 0;
  logic [63:0] mq [4][$];
  logic m_ovf = 0, m_unf = 0;

  sync_fifo_mc dut (
    .clk(clk), .rst_n(rst_n), .flush_en(flush_en),
    .enqueue_en(enqueue_en), .enqueue_chan(enqueue_chan), .value_i(value_i),
    .dequeue_en(dequeue_en), .dequeue_chan(dequeue_chan), .value_o(value_o),
    .full(full), .almost_full(almost_full), .empty(empty), .almost_empty(almost_empty),
    .count_o(count_o), .err_clr(err_clr),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < 4; c++) begin
      int n = mq[c].size();
      check($sformatf("count%0d", c), 64'(count_o[c*3 +: 3]), 64'(n));
      check($sformatf("full%0d", c), 64'(full[c]), 64'(n == SZ));
      check($sformatf("afull%0d", c), 64'(almost_full[c]), 64'(n >= SZ));
      check($sformatf("empty%0d", c), 64'(empty[c]), 64'(n == 0));
      check($sformatf("aempty%0d", c), 64'(almost_empty[c]), 64'(n <= 1));
    end
    check("overflow_err", 64'(overflow_err), 64'(m_ovf));
    check("underflow_err", 64'(underflow_err), 64'(m_unf));
  endtask

  task automatic step(input logic [3:0] fl, input logic ee, input logic [1:0] ec, input logic [63:0] v,
                      input logic de, input logic [1:0] dc, input logic clr);
    logic deq_ok, enq_ok, ovf, unf;
    flush_en = fl; enqueue_en = ee; enqueue_chan = ec; value_i = v;
    dequeue_en = de; dequeue_chan = dc; err_clr = clr;
    #1;
    if (mq[dc].size() > 0) check("value_o", value_o, mq[dc][0]);
    deq_ok = de && !fl[dc] && mq[dc].size() > 0;
    enq_ok = ee && !fl[ec] && (mq[ec].size() < SZ || (de && dc == ec));
    ovf = ee && !fl[ec] && !enq_ok;
    unf = de && !fl[dc] && !deq_ok;
    @(posedge clk);
    #1;
    if (deq_ok) void'(mq[dc].pop_front());
    if (enq_ok) mq[ec].push_back(v);
    for (int c = 0; c < 4; c++) if (fl[c]) mq[c].delete();
    m_ovf = ovf || (m_ovf && !clr);
    m_unf = unf || (m_unf && !clr);
    flush_en = 0; enqueue_en = 0; dequeue_en = 0; err_clr = 0;
    check_all();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    #1;
    check("reset_empty", 64'(empty), 64'hF);
    check("reset_count", 64'(count_o), 64'h0);
    check_all();
    // fill then drain ch2
    for (int i = 0; i < 4; i++) step(4'h0, 1, 2'd2, 64'hA0 + 64'(i), 0, 2'd0, 0);
    check("ch2_full", 64'(full[2]), 64'h1);
    check("ch2_count", 64'(count_o[6 +: 3]), 64'h4);
    for (int i = 0; i < 4; i++) begin
      dequeue_chan = 2'd2;
      #1;
      check("ch2_head", value_o, 64'hA0 + 64'(i));
      step(4'h0, 0, 2'd0, 0, 1, 2'd2, 0);
    end
    check("ch2_empty", 64'(empty[2]), 64'h1);
    // full channel with simultaneous enqueue and dequeue
    for (int i = 0; i < 4; i++) step(4'h0, 1, 2'd1, 64'hB0 + 64'(i), 0, 2'd0, 0);
    step(4'h0, 1, 2'd1, 64'h55, 1, 2'd1, 0);
    check("pass_count", 64'(count_o[3 +: 3]), 64'h4);
    for (int i = 0; i < 3; i++) step(4'h0, 0, 2'd0, 0, 1, 2'd1, 0);
    dequeue_chan = 2'd1;
    #1;
    check("pass_last", value_o, 64'h55);
    step(4'h0, 0, 2'd0, 0, 1, 2'd1, 0);
    check("pass_noerr", 64'(overflow_err), 64'h0);
    // underflow on ch0 while ch3 enqueues
    step(4'h0, 1, 2'd3, 64'h11, 1, 2'd0, 0);
    check("unf_set", 64'(underflow_err), 64'h1);
    step(4'h0, 0, 2'd0, 0, 0, 2'd0, 1);
    check("unf_clr", 64'(underflow_err), 64'h0);
    // flush ch0 overriding an enqueue to it
    for (int i = 0; i < 3; i++) step(4'h0, 1, 2'd0, 64'hC0 + 64'(i), 0, 2'd0, 0);
    for (int i = 0; i < 2; i++) step(4'h0, 1, 2'd1, 64'hD0 + 64'(i), 0, 2'd0, 0);
    step(4'h1, 1, 2'd0, 64'hEE, 0, 2'd0, 0);
    check("flush_c0", 64'(count_o[0 +: 3]), 64'h0);
    check("flush_c1", 64'(count_o[3 +: 3]), 64'h2);
    // asynchronous reset mid-cycle
    step(4'h0, 1, 2'd3, 64'h12, 0, 2'd0, 0);
    #2;
    rst_n = 0;
    #1;
    for (int c = 0; c < 4; c++) mq[c].delete();
    m_ovf = 0; m_unf = 0;
    check("async_empty", 64'(empty), 64'hF);
    check("async_count", 64'(count_o), 64'h0);
    check_all();
    @(negedge clk) rst_n = 1;
    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic [3:0] fl;
      fl = ($urandom_range(0, 24) == 0) ? 4'($urandom) : 4'h0;
      step(fl, $urandom_range(0, 2) != 0, 2'($urandom), {$urandom, $urandom},
           $urandom_range(0, 1) == 1, 2'($urandom), $urandom_range(0, 15) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
